// File: rtl/cpu_id_pkg.sv
// Shared decode constants and the ID->EX register bundle.
package cpu_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rfa;
        logic [31:0] rfb;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rf_dest;
        logic        rfw;
        logic [1:0]  wbsource;
        logic [1:0]  drw;
        logic        b;
        logic        j;
        logic        jr;
        logic [31:0] jaddr;
    } id_ex_t;

endpackage

// File: rtl/cpu_id_if.sv
// Decode-stage bus: fetch registers, writeback port, and the EX-bound bundle.
interface cpu_id_if;
    logic        cpu_stall;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] p_pc;
    logic [31:0] p_rfa;
    logic [31:0] p_rfb;
    logic [31:0] p_imm;
    logic [4:0]  p_shamt;
    logic [5:0]  p_op;
    logic [5:0]  p_func;
    logic [4:0]  p_rf_dest;
    logic        p_c_rfw;
    logic [1:0]  p_c_wbsource;
    logic [1:0]  p_c_drw;
    logic        p_c_b;
    logic        p_c_j;
    logic        p_c_jr;
    logic [31:0] p_jaddr;

    modport master (
        output cpu_stall, flush, if_pc, if_inst, wb_we, wb_rd, wb_data,
        input  stall, p_pc, p_rfa, p_rfb, p_imm, p_shamt, p_op, p_func,
        input  p_rf_dest, p_c_rfw, p_c_wbsource, p_c_drw, p_c_b, p_c_j,
        input  p_c_jr, p_jaddr
    );

    modport slave (
        input  cpu_stall, flush, if_pc, if_inst, wb_we, wb_rd, wb_data,
        output stall, p_pc, p_rfa, p_rfb, p_imm, p_shamt, p_op, p_func,
        output p_rf_dest, p_c_rfw, p_c_wbsource, p_c_drw, p_c_b, p_c_j,
        output p_c_jr, p_jaddr
    );
endinterface

// File: rtl/cpu_id_rf.sv
// 32x32 register file: two async reads with write-through, one gated write.
module cpu_id_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stall,
    input  logic [4:0]  ra_idx,
    input  logic [4:0]  rb_idx,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  wd_idx,
    input  logic [31:0] wd
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    function automatic logic [31:0] rd_port(input logic [4:0] idx);
        if (idx == 5'd0)
            return 32'd0;
        else if (we && wd_idx == idx)
            return wd;
        else
            return regs_q[idx];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (we && !cpu_stall && wd_idx != 5'd0)
            regs_d[wd_idx] = wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    assign ra_data = rd_port(ra_idx);
    assign rb_data = rd_port(rb_idx);
endmodule

// File: rtl/cpu_id.sv
// Decode stage: field decode, operand read, load-use detection, ID/EX register.
import cpu_id_pkg::*;

module cpu_id (
    input logic       clk,
    input logic       rst,
    cpu_id_if.slave   bus
);
    id_ex_t      p_q, p_d, dec;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, dest;
    logic [15:0] imm;
    logic [31:0] rfa, rfb;
    logic [3:0]  pc4_hi;
    logic        valid, wr, uses_rs, uses_rt, stall;

    assign op   = bus.if_inst[31:26];
    assign rs   = bus.if_inst[25:21];
    assign rt   = bus.if_inst[20:16];
    assign rd   = bus.if_inst[15:11];
    assign func = bus.if_inst[5:0];
    assign imm  = bus.if_inst[15:0];

    // upper nibble of pc+4 without a full 32-bit adder
    assign pc4_hi = bus.if_pc[31:28] + {3'b000, &bus.if_pc[27:2]};

    cpu_id_rf u_rf (
        .clk       (clk),
        .rst       (rst),
        .cpu_stall (bus.cpu_stall),
        .ra_idx    (rs),
        .rb_idx    (rt),
        .ra_data   (rfa),
        .rb_data   (rfb),
        .we        (bus.wb_we),
        .wd_idx    (bus.wb_rd),
        .wd        (bus.wb_data)
    );

    always_comb begin
        dec     = '0;
        valid   = 1'b1;
        wr      = 1'b0;
        dest    = rt;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                dest    = rd;
                wr      = 1'b1;
                if (func == FN_JR) begin
                    wr     = 1'b0;
                    dec.jr = 1'b1;
                end
                if (func == FN_JALR) begin
                    dest         = REG_RA;
                    dec.jr       = 1'b1;
                    dec.wbsource = WB_PC4;
                end
                if (func == FN_SLL || func == FN_SRL)
                    uses_rs = 1'b0;
            end
            OP_J: begin
                uses_rs = 1'b0;
                dec.j   = 1'b1;
                dest    = 5'd0;
            end
            OP_JAL: begin
                uses_rs      = 1'b0;
                dec.j        = 1'b1;
                wr           = 1'b1;
                dest         = REG_RA;
                dec.wbsource = WB_PC4;
            end
            OP_BEQ, OP_BNE: begin
                uses_rt = 1'b1;
                dec.b   = 1'b1;
                dest    = 5'd0;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: wr = 1'b1;
            OP_LUI: begin
                uses_rs = 1'b0;
                wr      = 1'b1;
            end
            OP_LW: begin
                wr           = 1'b1;
                dec.drw      = 2'b10;
                dec.wbsource = WB_MEM;
            end
            OP_SW: begin
                uses_rt = 1'b1;
                dec.drw = 2'b01;
                dest    = 5'd0;
            end
            default: valid = 1'b0;
        endcase
        dec.pc      = bus.if_pc;
        dec.rfa     = rfa;
        dec.rfb     = rfb;
        dec.imm     = (op == OP_ANDI || op == OP_ORI) ? {16'h0, imm}
                                                      : {{16{imm[15]}}, imm};
        dec.shamt   = bus.if_inst[10:6];
        dec.op      = op;
        dec.func    = func;
        dec.rf_dest = dest;
        dec.rfw     = wr && dest != 5'd0;
        dec.jaddr   = {pc4_hi, bus.if_inst[25:0], 2'b00};
        if (!valid)
            dec = '0;
    end

    assign stall = p_q.drw[1] && p_q.rf_dest != 5'd0 &&
                   ((uses_rs && rs == p_q.rf_dest) ||
                    (uses_rt && rt == p_q.rf_dest));

    always_comb begin
        p_d = p_q;
        if (!bus.cpu_stall)
            p_d = (bus.flush || stall) ? '0 : dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            p_q <= '0;
        else
            p_q <= p_d;
    end

    assign bus.stall        = stall;
    assign bus.p_pc         = p_q.pc;
    assign bus.p_rfa        = p_q.rfa;
    assign bus.p_rfb        = p_q.rfb;
    assign bus.p_imm        = p_q.imm;
    assign bus.p_shamt      = p_q.shamt;
    assign bus.p_op         = p_q.op;
    assign bus.p_func       = p_q.func;
    assign bus.p_rf_dest    = p_q.rf_dest;
    assign bus.p_c_rfw      = p_q.rfw;
    assign bus.p_c_wbsource = p_q.wbsource;
    assign bus.p_c_drw      = p_q.drw;
    assign bus.p_c_b        = p_q.b;
    assign bus.p_c_j        = p_q.j;
    assign bus.p_c_jr       = p_q.jr;
    assign bus.p_jaddr      = p_q.jaddr;
endmodule

// File: tb/tb_cpu_id.sv
// Random + directed bench for cpu_id against an instruction-level reference model.
import cpu_id_pkg::*;

module tb_cpu_id;
    logic clk = 1'b0;
    logic rst;
    cpu_id_if bus ();

    cpu_id dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    id_ex_t      m_p;
    logic [31:0] m_rf [32];

    task automatic chk(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic id_ex_t dut_p();
        id_ex_t d;
        d = '{bus.p_pc, bus.p_rfa, bus.p_rfb, bus.p_imm, bus.p_shamt,
              bus.p_op, bus.p_func, bus.p_rf_dest, bus.p_c_rfw,
              bus.p_c_wbsource, bus.p_c_drw, bus.p_c_b, bus.p_c_j,
              bus.p_c_jr, bus.p_jaddr};
        return d;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] i);
        if (i == 0) return 32'd0;
        if (bus.wb_we && bus.wb_rd == i) return bus.wb_data;
        return m_rf[i];
    endfunction

    function automatic id_ex_t m_dec();
        id_ex_t d;
        logic [31:0] in, pc4;
        logic [5:0] op, f;
        logic is_jal, is_jr, wr;
        logic [4:0] dst;
        in = bus.if_inst;
        op = in[31:26];
        f  = in[5:0];
        d  = '0;
        if (!(op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU,
                         OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI,
                         OP_LW, OP_SW}))
            return d;
        pc4    = bus.if_pc + 32'd4;
        is_jal = op == OP_JAL || (op == OP_RTYPE && f == FN_JALR);
        is_jr  = op == OP_RTYPE && f == FN_JR;
        wr     = !is_jr && (op inside {OP_RTYPE, OP_ADDIU, OP_SLTI,
                  OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_JAL});
        dst    = is_jal ? 5'd31 : op == OP_RTYPE ? in[15:11]
               : wr ? in[20:16] : 5'd0;
        d.pc       = bus.if_pc;
        d.rfa      = m_read(in[25:21]);
        d.rfb      = m_read(in[20:16]);
        d.imm      = (op == OP_ANDI || op == OP_ORI) ? 32'(in[15:0])
                   : 32'(signed'(in[15:0]));
        d.shamt    = in[10:6];
        d.op       = op;
        d.func     = f;
        d.rf_dest  = dst;
        d.rfw      = wr && dst != 0;
        d.wbsource = is_jal ? 2'd2 : op == OP_LW ? 2'd1 : 2'd0;
        d.drw      = op == OP_LW ? 2'b10 : op == OP_SW ? 2'b01 : 2'b00;
        d.b        = op == OP_BEQ || op == OP_BNE;
        d.j        = op == OP_J || op == OP_JAL;
        d.jr       = op == OP_RTYPE && (f == FN_JR || f == FN_JALR);
        d.jaddr    = {pc4[31:28], in[25:0], 2'b00};
        return d;
    endfunction

    function automatic logic m_stall();
        logic [5:0] op, f;
        logic [4:0] rs, rt;
        logic urs, urt;
        op  = bus.if_inst[31:26];
        f   = bus.if_inst[5:0];
        rs  = bus.if_inst[25:21];
        rt  = bus.if_inst[20:16];
        urs = !(op inside {OP_J, OP_JAL, OP_LUI} ||
                (op == OP_RTYPE && (f == FN_SLL || f == FN_SRL)));
        urt = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
        return m_p.drw == 2'b10 && m_p.rf_dest != 0 &&
               ((urs && rs == m_p.rf_dest) || (urt && rt == m_p.rf_dest));
    endfunction

    task automatic m_reset();
        m_p = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    // called just after a negedge with inputs already applied
    task automatic tick();
        id_ex_t nx;
        logic   st;
        #1;
        st = m_stall();
        chk("stall", 192'(bus.stall), 192'(st));
        nx = m_dec();
        @(posedge clk);
        if (!bus.cpu_stall) begin
            if (bus.wb_we && bus.wb_rd != 0) m_rf[bus.wb_rd] = bus.wb_data;
            m_p = (bus.flush || st) ? '0 : nx;
        end
        #1;
        chk("p_bundle", 192'(dut_p()), 192'(m_p));
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic fl, input logic cs, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd);
        bus.if_inst   = inst;
        bus.if_pc     = pc;
        bus.flush     = fl;
        bus.cpu_stall = cs;
        bus.wb_we     = we;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
    endtask

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            3:       return 5'd10;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [5:0] ops [13];
        logic [5:0] fns [6];
        logic [5:0] op, f;
        ops = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI,
                OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
        fns = '{FN_SLL, FN_SRL, FN_JR, FN_JALR, 6'h21, 6'h2A};
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom)
           : ops[$urandom_range(0, 12)];
        f  = ($urandom_range(0, 5) == 0) ? 6'($urandom)
           : fns[$urandom_range(0, 5)];
        return {op, rreg(), rreg(), rreg(), 5'($urandom), f};
    endfunction

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_bundle", 192'(dut_p()), 192'(0));
        chk("rst_stall", 192'(bus.stall), 192'(0));
        rst = 1'b0;

        drive(32'h2408FFFF, 32'h10, 0, 0, 0, 5'd0, 32'h0);
        tick();
        chk("addiu_imm", 192'(bus.p_imm), 192'(32'hFFFFFFFF));
        chk("addiu_dst", 192'({bus.p_rf_dest, bus.p_c_rfw,
                               bus.p_c_wbsource}), 192'({5'd8, 1'b1, 2'd0}));
        drive(32'h3508FFFF, 32'h14, 0, 0, 0, 5'd0, 32'h0);
        tick();
        chk("ori_imm", 192'(bus.p_imm), 192'(32'h0000FFFF));

        drive(32'h8D280000, 32'h18, 0, 0, 0, 5'd0, 32'h0);
        tick();
        drive(32'h01085021, 32'h1C, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("lu_stall1", 192'(bus.stall), 192'(1));
        #0 tick();
        chk("lu_bubble", 192'(dut_p()), 192'(0));
        #1 chk("lu_stall0", 192'(bus.stall), 192'(0));
        tick();
        chk("lu_issue", 192'(bus.p_rf_dest), 192'(5'd10));

        drive(32'h8D280000, 32'h20, 0, 0, 0, 5'd0, 32'h0);
        tick();
        drive(32'hAD280004, 32'h24, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("sw_stall", 192'(bus.stall), 192'(1));
        tick();
        tick();
        drive(32'h8D200000, 32'h28, 0, 0, 0, 5'd0, 32'h0);
        tick();
        drive(32'h00005021, 32'h2C, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("lw0_nostall", 192'(bus.stall), 192'(0));
        tick();

        drive(32'h25090000, 32'h30, 0, 0, 1, 5'd8, 32'h00001234);
        tick();
        chk("wthru", 192'(bus.p_rfa), 192'(32'h00001234));
        drive(32'h24090000, 32'h34, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        tick();
        chk("r0_zero", 192'(bus.p_rfa), 192'(0));

        drive(32'h0C000010, 32'h00000100, 0, 0, 0, 5'd0, 32'h0);
        tick();
        chk("jal_addr", 192'(bus.p_jaddr), 192'(32'h00000040));
        chk("jal_ctl", 192'({bus.p_rf_dest, bus.p_c_j, bus.p_c_rfw,
                             bus.p_c_wbsource}), 192'({5'd31, 1'b1, 1'b1, 2'd2}));
        drive(32'h0C000010, 32'h00000100, 1, 0, 0, 5'd0, 32'h0);
        tick();
        chk("jal_flush", 192'(dut_p()), 192'(0));

        drive(32'h25280000, 32'h40, 0, 0, 0, 5'd0, 32'h0);
        tick();
        drive(32'h25280000, 32'h40, 0, 1, 1, 5'd9, 32'hDEADBEEF);
        repeat (3) tick();
        drive(32'h25280000, 32'h40, 0, 0, 0, 5'd0, 32'h0);
        tick();
        chk("cstall_rf", 192'(bus.p_rfa), 192'(0));

        drive(32'h8D280000, 32'h50, 0, 0, 1, 5'd8, 32'h55);
        tick();
        drive(32'h01085021, 32'h54, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("rst_pre", 192'(bus.stall), 192'(1));
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_async", 192'(dut_p()), 192'(0));
        chk("rst_async_st", 192'(bus.stall), 192'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(32'h25090000, 32'h58, 0, 0, 0, 5'd0, 32'h0);
        tick();
        chk("rst_rf", 192'(bus.p_rfa), 192'(0));

        for (int i = 0; i < 3000; i++) begin
            drive(rnd_inst(), $urandom & 32'hFFFFFFFC,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, rreg(), $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_id.md
Name: cpu_id

Overview:
- Instruction decode stage, directly downstream of the fetch stage.
- Consumes the fetch pipeline registers (p_pc, p_inst) and reads the 32x32 register file.
- Produces decoded operands and control for the execute stage.
- Detects load-use hazards, drives the stall back to fetch, and inserts bubbles on stall or on branch/jump flush.

Parameters:
- None. ISA widths are fixed at 32-bit data and 5-bit register indices.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_stall  in  1  global freeze; all state holds, including register file writes.
- flush  in  1  taken branch or jump resolved in EX (pc_b | pc_j).
- if_pc  in  32  PC of the instruction in fetch's pipeline register.
- if_inst  in  32  instruction from fetch's pipeline register.
- wb_we  in  1  writeback enable.
- wb_rd  in  5  writeback register index.
- wb_data  in  32  writeback data.
- stall  out  1  combinational load-use hazard; fetch holds its registers.
- p_pc  out  32  registered PC.
- p_rfa  out  32  rs operand.
- p_rfb  out  32  rt operand.
- p_imm  out  32  extended immediate.
- p_shamt  out  5  shift amount.
- p_op  out  6  opcode, for ALU decode in EX.
- p_func  out  6  function field, for ALU decode in EX.
- p_rf_dest  out  5  destination register.
- p_c_rfw  out  1  register write.
- p_c_wbsource  out  2  0=ALU, 1=memory, 2=PC+4.
- p_c_drw  out  2  {read, write} data memory.
- p_c_b  out  1  conditional branch.
- p_c_j  out  1  jump.
- p_c_jr  out  1  jump register.
- p_jaddr  out  32  jump target.

Behaviour:
- Field extraction:
  - op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], func=[5:0], imm=[15:0].
- Opcodes decoded:
  - R-type 0x00, j 0x02, jal 0x03, beq 0x04, bne 0x05, addiu 0x09, slti 0x0A, sltiu 0x0B, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.
  - Any other opcode decodes as a bubble.
- Immediate extension:
  - andi and ori zero-extend.
  - All other opcodes sign-extend.
- p_jaddr = {if_pc[31:28]+carry of if_pc+4, target[25:0], 2'b00}, where target = if_inst[25:0]. Precisely: the upper 4 bits come from (if_pc+4)[31:28].
- Destination register:
  - R-type: rd.
  - I-type writers: rt.
  - jal and jalr: 31.
  - Any destination of 0 forces p_c_rfw=0.
- Write/memory control:
  - p_c_rfw=1 for R-type (except jr), addiu, slti, sltiu, andi, ori, lui, lw, jal.
  - jr: func 0x08. jalr: func 0x09.
  - lw: p_c_drw=2'b10, p_c_wbsource=1.
  - sw: p_c_drw=2'b01.
  - jal and jalr: p_c_wbsource=2.
- Register file (sub-module):
  - Two combinational reads and one write.
  - Writes occur on the rising edge when wb_we && !cpu_stall && wb_rd!=0.
  - Register 0 always reads 0.
  - Write-through: if wb_we && wb_rd==read index && index!=0, the read returns wb_data in the same cycle.
- Register source usage:
  - uses_rs: every opcode except j, jal, lui, and R-type sll/srl (func 0x00/0x02).
  - uses_rt: R-type, beq, bne, sw.
- Hazard detection:
  - stall = p_c_drw[1] && p_rf_dest!=0 && ((uses_rs && rs==p_rf_dest) || (uses_rt && rt==p_rf_dest)).
  - Combinational, from the current outputs and if_inst.
- Clock edge, in priority order:
  1. rst (asynchronous): all p_* outputs and all 32 registers go to 0. stall therefore reads 0.
  2. cpu_stall: hold everything.
  3. flush or stall: load a bubble (all p_* = 0, i.e. sll $0 with no writes).
  4. Otherwise: register the decoded values.
- Latency: 1 cycle from if_inst to p_* outputs.
- A load-use stall lasts exactly one cycle, because the bubble clears p_c_drw.
- flush with stall at the same time:
  - Bubble is loaded.
  - Fetch gives flush priority, so the stalled instruction is discarded.
- Reset asserted mid-stall clears everything immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW).
  - Function codes (FN_SLL, FN_SRL, FN_JR, FN_JALR).
  - wbsource encodings (WB_ALU, WB_MEM, WB_PC4).
- One sub-module, cpu_id_rf:
  - 32x32 register file with asynchronous clear, write-through and a hardwired zero register.
  - Gated by cpu_stall.

Test Plan:
- Reset: drive arbitrary state, assert rst between clock edges -> all p_* = 0 and stall=0 immediately; reading any register afterwards returns 0.
- if_inst=0x2408FFFF (addiu $8,$0,-1) -> next edge p_imm=0xFFFFFFFF, p_rf_dest=8, p_c_rfw=1, p_c_wbsource=0. if_inst=0x3508FFFF (ori) -> p_imm=0x0000FFFF.
- Load-use: lw $8,0($9) (0x8D280000) followed by addu $10,$8,$8 (0x01085021) -> stall=1 for exactly one cycle and p_* is a bubble for that cycle; the next edge issues addu with p_rf_dest=10. Repeat with sw $8 (rt use) and with lw $0 (no stall).
- Write-through: wb_we=1, wb_rd=8, wb_data=0x00001234 in the same cycle as if_inst reads rs=8 -> p_rfa=0x00001234. wb_rd=0 with data 0xFFFFFFFF -> $0 still reads 0.
- jal 0x0C000010 at if_pc=0x00000100 -> p_jaddr=0x00000040, p_rf_dest=31, p_c_j=1, p_c_rfw=1, p_c_wbsource=2. Assert flush the same cycle -> bubble instead.
- cpu_stall=1 for 3 cycles with wb_we=1 -> p_* unchanged and the register file is not written; after release, decode resumes from the held if_inst.
